dcache_wb_buffer: RTL and testbench

//  Write-back (victim) buffer downstream of the dcache tag/data register arrays.
//  - Accepts dirty lines evicted by the dcache controller and drains them to memory in FIFO order.
//  - This lets the refill read proceed without waiting for the write-back.
//  - Optionally forwards buffered lines to the cache on a refill to a line still in the buffer.

---
 rtl/dcache_pkg.sv | 21 ++
 rtl/dcache_wb_entry_array.sv | 95 +++++++++
 rtl/dcache_wb_buffer.sv | 106 ++++++++++
 tb/tb_dcache_wb_buffer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// dcache_pkg: shared types and default widths for the dcache write-back path.
//   wb_state_t  - drain FSM state (WB_IDLE, WB_WRITE)
//   wb_entry_t  - one buffered victim line: line tag (address without the
//                 byte offset) plus the full line data, at default widths
package dcache_pkg;

  localparam int DCACHE_LINE_W = 256;
  localparam int DCACHE_ADDR_W = 32;
  localparam int DCACHE_OFF_W  = $clog2(DCACHE_LINE_W / 8);

  typedef enum logic [0:0] {
    WB_IDLE  = 1'b0,
    WB_WRITE = 1'b1
  } wb_state_t;

  typedef struct packed {
    logic [DCACHE_ADDR_W-DCACHE_OFF_W-1:0] tag;
    logic [DCACHE_LINE_W-1:0]              data;
  } wb_entry_t;

endpackage

// File: rtl/dcache_wb_entry_array.sv
// dcache_wb_entry_array: DEPTH-slot storage for the write-back buffer.
//   clk, rst           clock, async active-low reset (clears valid bits only)
//   wr_en/wr_ptr/...   single write port, slot becomes valid next cycle
//   pop_en             invalidates the slot at head_ptr
//   head_ptr           registered read pointer -> head_tag / head_data
//   lookup_tag         line tag to forward-match
//   lookup_hit/data    youngest valid matching slot (only with DCACHE_WB_FWD_EN)
// Build option: define DCACHE_WB_FWD_EN to enable forwarding; otherwise the
// lookup outputs are tied to zero.
module dcache_wb_entry_array
  import dcache_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int TAG_W  = DCACHE_ADDR_W - DCACHE_OFF_W,
  parameter int LINE_W = DCACHE_LINE_W,
  parameter int PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [PTR_W-1:0]  wr_ptr,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [LINE_W-1:0] wr_data,
  input  logic              pop_en,
  input  logic [PTR_W-1:0]  head_ptr,
  output logic [TAG_W-1:0]  head_tag,
  output logic [LINE_W-1:0] head_data,
  input  logic [TAG_W-1:0]  lookup_tag,
  output logic              lookup_hit,
  output logic [LINE_W-1:0] lookup_data
);

  // Same layout as wb_entry_t, but following this instance's widths.
  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [LINE_W-1:0] data;
  } entry_t;

  entry_t           ent_q [DEPTH];
  entry_t           ent_d [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;

  always_comb begin
    ent_d = ent_q;
    vld_d = vld_q;
    if (pop_en) vld_d[head_ptr] = 1'b0;
    if (wr_en) begin
      ent_d[wr_ptr].tag  = wr_tag;
      ent_d[wr_ptr].data = wr_data;
      vld_d[wr_ptr]      = 1'b1;
    end
  end

  // Line storage needs no reset; validity is tracked separately.
  always_ff @(posedge clk) ent_q <= ent_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) vld_q <= '0;
    else      vld_q <= vld_d;
  end

  assign head_tag  = ent_q[head_ptr].tag;
  assign head_data = ent_q[head_ptr].data;

`ifdef DCACHE_WB_FWD_EN
  logic [DEPTH-1:0] match_vec;
  logic [PTR_W-1:0] idx;

  always_comb begin
    match_vec = '0;
    for (int i = 0; i < DEPTH; i++)
      match_vec[i] = vld_q[i] && (ent_q[i].tag == lookup_tag);
  end

  // Walk oldest -> youngest starting at head; the last match is the youngest.
  always_comb begin
    lookup_hit  = 1'b0;
    lookup_data = '0;
    idx         = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_ptr + PTR_W'(i);
      if (match_vec[idx]) begin
        lookup_hit  = 1'b1;
        lookup_data = ent_q[idx].data;
      end
    end
  end
`else
  logic unused_fwd;
  assign unused_fwd  = ^{lookup_tag, vld_q};
  assign lookup_hit  = 1'b0;
  assign lookup_data = '0;
`endif

endmodule

// File: rtl/dcache_wb_buffer.sv
// dcache_wb_buffer: victim write-back FIFO between the dcache and memory.
//   push_valid/ready/addr/data  evicted dirty line in (ready = not full)
//   mem_write/addr/wdata        head line write request, held until mem_resp
//   mem_resp                    one-cycle write-complete pulse
//   lookup_addr/hit/data        refill forwarding lookup (combinational)
//   empty                       no lines buffered
// Build option: DCACHE_WB_FWD_EN enables forwarding from buffered lines.
module dcache_wb_buffer
  import dcache_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = DCACHE_ADDR_W,
  parameter int LINE_W = DCACHE_LINE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_valid,
  output logic              push_ready,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [LINE_W-1:0] push_data,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic              mem_resp,
  input  logic [ADDR_W-1:0] lookup_addr,
  output logic              lookup_hit,
  output logic [LINE_W-1:0] lookup_data,
  output logic              empty
);

  localparam int OFF_W = $clog2(LINE_W / 8);
  localparam int TAG_W = ADDR_W - OFF_W;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  wb_state_t        state_q, state_d;
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push_fire, pop_fire;
  logic [TAG_W-1:0] head_tag;
  logic             unused_off;

  // Byte offsets never reach the array; mem_addr re-zeroes them.
  assign unused_off = ^{push_addr[OFF_W-1:0], lookup_addr[OFF_W-1:0]};

  // Ready comes from the registered count only, so a pop frees a slot
  // for pushes from the following cycle.
  assign push_ready = (cnt_q != CNT_FULL);
  assign push_fire  = push_valid & push_ready;
  assign mem_write  = (state_q == WB_WRITE);
  assign pop_fire   = mem_write & mem_resp;
  assign empty      = (cnt_q == '0);
  assign mem_addr   = {head_tag, {OFF_W{1'b0}}};

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    unique case (state_q)
      WB_IDLE:  if (cnt_q != '0) state_d = WB_WRITE;
      // Always go back through IDLE so mem_write drops between requests.
      WB_WRITE: if (mem_resp)    state_d = WB_IDLE;
      default:                   state_d = WB_IDLE;
    endcase
    if (push_fire) tail_d = tail_q + PTR_W'(1);
    if (pop_fire)  head_d = head_q + PTR_W'(1);
    cnt_d = cnt_q + CNT_W'(push_fire) - CNT_W'(pop_fire);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= WB_IDLE;
      head_q  <= '0;
      tail_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      cnt_q   <= cnt_d;
    end
  end

  dcache_wb_entry_array #(
    .DEPTH (DEPTH),
    .TAG_W (TAG_W),
    .LINE_W(LINE_W),
    .PTR_W (PTR_W)
  ) u_array (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (push_fire),
    .wr_ptr     (tail_q),
    .wr_tag     (push_addr[ADDR_W-1:OFF_W]),
    .wr_data    (push_data),
    .pop_en     (pop_fire),
    .head_ptr   (head_q),
    .head_tag   (head_tag),
    .head_data  (mem_wdata),
    .lookup_tag (lookup_addr[ADDR_W-1:OFF_W]),
    .lookup_hit (lookup_hit),
    .lookup_data(lookup_data)
  );

endmodule

// File: tb/tb_dcache_wb_buffer.sv
// tb_dcache_wb_buffer: directed table + corner sequences + random drain
// scoreboard for dcache_wb_buffer (DEPTH=2). Honors DCACHE_WB_FWD_EN.
module tb_dcache_wb_buffer;

  localparam int DEPTH  = 2;
  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;
`ifdef DCACHE_WB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              push_valid = 1'b0;
  logic              push_ready;
  logic [ADDR_W-1:0] push_addr = '0;
  logic [LINE_W-1:0] push_data = '0;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic              mem_resp = 1'b0;
  logic [ADDR_W-1:0] lookup_addr = '0;
  logic              lookup_hit;
  logic [LINE_W-1:0] lookup_data;
  logic              empty;

  always #5 clk = ~clk;

  dcache_wb_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk(clk), .rst(rst),
    .push_valid(push_valid), .push_ready(push_ready),
    .push_addr(push_addr), .push_data(push_data),
    .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_resp(mem_resp),
    .lookup_addr(lookup_addr), .lookup_hit(lookup_hit), .lookup_data(lookup_data),
    .empty(empty)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [LINE_W-1:0] got,
                     input logic [LINE_W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic logic [LINE_W-1:0] pat(input logic [ADDR_W-1:0] a);
    return {8{a}};
  endfunction

  typedef struct {
    logic        pv;
    logic [31:0] addr;
    logic        resp;
    logic        e_pr;
    logic        e_mw;
    logic        e_empty;
    logic [31:0] e_addr;
  } vec_t;

  vec_t tbl [16];

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [LINE_W-1:0] d;
  } exp_t;

  exp_t sb [$];

  task automatic push_line(input logic [ADDR_W-1:0] a, input logic [LINE_W-1:0] d);
    int n = 0;
    @(negedge clk);
    while (!push_ready && n < 50) begin @(negedge clk); n++; end
    chk("push wait", 256'(n < 50), 256'(1));
    push_valid = 1'b1; push_addr = a; push_data = d;
    @(negedge clk);
    push_valid = 1'b0;
  endtask

  task automatic wait_mw(input string nm);
    int n = 0;
    while (!mem_write && n < 50) begin @(negedge clk); n++; end
    chk(nm, 256'(n < 50), 256'(1));
  endtask

  task automatic drain_one(input logic [ADDR_W-1:0] a, input logic [LINE_W-1:0] d);
    @(negedge clk);
    wait_mw("drain wait");
    chk("drain addr", mem_addr, a);
    chk("drain data", mem_wdata, d);
    mem_resp = 1'b1;
    @(negedge clk);
    mem_resp = 1'b0;
  endtask

  logic [LINE_W-1:0] d1, d2;

  initial begin
    //            pv  addr        resp  pr  mw  empty  mem_addr
    tbl[0]  = '{1'b1, 32'h1040, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
    tbl[1]  = '{1'b0, 32'h0,    1'b0, 1'b1, 1'b1, 1'b0, 32'h1040};
    tbl[2]  = '{1'b0, 32'h0,    1'b1, 1'b1, 1'b0, 1'b1, 32'h0};
    tbl[3]  = '{1'b0, 32'h0,    1'b0, 1'b1, 1'b0, 1'b1, 32'h0};
    tbl[4]  = '{1'b1, 32'h100,  1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
    tbl[5]  = '{1'b1, 32'h200,  1'b0, 1'b0, 1'b1, 1'b0, 32'h100};
    tbl[6]  = '{1'b1, 32'h300,  1'b0, 1'b0, 1'b1, 1'b0, 32'h100};  // full: ignored
    tbl[7]  = '{1'b0, 32'h0,    1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
    tbl[8]  = '{1'b0, 32'h0,    1'b0, 1'b1, 1'b1, 1'b0, 32'h200};
    tbl[9]  = '{1'b0, 32'h0,    1'b1, 1'b1, 1'b0, 1'b1, 32'h0};
    tbl[10] = '{1'b1, 32'h500,  1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
    tbl[11] = '{1'b0, 32'h0,    1'b0, 1'b1, 1'b1, 1'b0, 32'h500};
    tbl[12] = '{1'b1, 32'h600,  1'b1, 1'b1, 1'b0, 1'b0, 32'h0};    // push+pop
    tbl[13] = '{1'b0, 32'h0,    1'b0, 1'b1, 1'b1, 1'b0, 32'h600};
    tbl[14] = '{1'b0, 32'h0,    1'b1, 1'b1, 1'b0, 1'b1, 32'h0};
    tbl[15] = '{1'b0, 32'h0,    1'b1, 1'b1, 1'b0, 1'b1, 32'h0};    // stray resp

    // reset values
    #1;
    chk("rst push_ready", 256'(push_ready), 256'(1));
    chk("rst mem_write", 256'(mem_write), 256'(0));
    chk("rst empty", 256'(empty), 256'(1));
    chk("rst lookup_hit", 256'(lookup_hit), 256'(0));
    @(negedge clk);
    rst = 1'b1;

    // directed table
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      push_valid = tbl[i].pv;
      push_addr  = tbl[i].addr;
      push_data  = pat(tbl[i].addr);
      mem_resp   = tbl[i].resp;
      @(posedge clk);
      #1;
      chk($sformatf("row%0d push_ready", i), 256'(push_ready), 256'(tbl[i].e_pr));
      chk($sformatf("row%0d mem_write", i), 256'(mem_write), 256'(tbl[i].e_mw));
      chk($sformatf("row%0d empty", i), 256'(empty), 256'(tbl[i].e_empty));
      if (tbl[i].e_mw) begin
        chk($sformatf("row%0d mem_addr", i), 256'(mem_addr), 256'(tbl[i].e_addr));
        chk($sformatf("row%0d mem_wdata", i), mem_wdata, pat(tbl[i].e_addr));
      end
    end
    @(negedge clk);
    push_valid = 1'b0; mem_resp = 1'b0;

    // forwarding: duplicate line, youngest wins
    d1 = {32{8'hA5}};
    d2 = {32{8'h3C}};
    push_line(32'h300, d1);
    push_line(32'h300, d2);
    lookup_addr = 32'h31C;
    #1;
    chk("fwd dup hit", 256'(lookup_hit), 256'(FWD));
    chk("fwd dup data", lookup_data, FWD ? d2 : '0);
    lookup_addr = 32'h400;
    #1;
    chk("fwd miss hit", 256'(lookup_hit), 256'(0));
    chk("fwd miss data", lookup_data, '0);
    drain_one(32'h300, d1);
    lookup_addr = 32'h31C;
    #1;
    chk("fwd after pop hit", 256'(lookup_hit), 256'(FWD));
    chk("fwd after pop data", lookup_data, FWD ? d2 : '0);
    drain_one(32'h300, d2);
    #1;
    chk("fwd drained hit", 256'(lookup_hit), 256'(0));
    chk("fwd drained empty", 256'(empty), 256'(1));

    // reset in the middle of a write
    push_line(32'h700, pat(32'h700));
    wait_mw("rst mid wait");
    #2 rst = 1'b0;
    #1;
    chk("midrst mem_write", 256'(mem_write), 256'(0));
    chk("midrst empty", 256'(empty), 256'(1));
    chk("midrst push_ready", 256'(push_ready), 256'(1));
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("postrst mem_write", 256'(mem_write), 256'(0));
    @(negedge clk);
    mem_resp = 1'b1;
    @(negedge clk);
    mem_resp = 1'b0;
    @(posedge clk); #1;
    chk("postrst resp mem_write", 256'(mem_write), 256'(0));
    chk("postrst resp empty", 256'(empty), 256'(1));

    // random pushes with random write latency
    fork
      begin : producer
        int k = 0;
        int cyc = 0;
        logic [ADDR_W-1:0] a;
        logic [LINE_W-1:0] d;
        while (k < 20 && cyc < 3000) begin
          @(negedge clk);
          cyc++;
          if (push_ready && $urandom_range(0, 3) != 0) begin
            a = $urandom;
            for (int j = 0; j < 8; j++) d[j*32 +: 32] = $urandom;
            push_valid = 1'b1; push_addr = a; push_data = d;
            sb.push_back('{a & 32'hFFFF_FFE0, d});
            k++;
          end else begin
            push_valid = 1'b0;
          end
        end
        @(negedge clk);
        push_valid = 1'b0;
        chk("rnd pushes", 256'(k), 256'(20));
      end
      begin : consumer
        int got = 0;
        int cyc = 0;
        int lat;
        exp_t e;
        while (got < 20 && cyc < 3000) begin
          @(negedge clk);
          cyc++;
          if (mem_write) begin
            if (sb.size() == 0) begin
              chk("rnd unexpected write", 256'(1), 256'(0));
            end else begin
              e = sb.pop_front();
              chk("rnd addr", 256'(mem_addr), 256'(e.a));
              chk("rnd data", mem_wdata, e.d);
            end
            lat = $urandom_range(0, 4);
            repeat (lat) @(negedge clk);
            chk("rnd held", 256'(mem_write), 256'(1));
            mem_resp = 1'b1;
            @(negedge clk);
            mem_resp = 1'b0;
            got++;
          end
        end
        chk("rnd drained", 256'(got), 256'(20));
      end
    join
    @(negedge clk);
    chk("rnd sb empty", 256'(sb.size()), 256'(0));
    chk("rnd dut empty", 256'(empty), 256'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
